// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC iteration controller: FSM states,
// system/mode encodings and the hyperbolic repeat schedule.
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic SYS_CIRCULAR   = 1'b1;
  localparam logic SYS_HYPERBOLIC = 1'b0;
  localparam logic MODE_ROTATION  = 1'b1;
  localparam logic MODE_VECTORING = 1'b0;

  localparam int ITER_W = 5;

  // Hyperbolic CORDIC must repeat these indices to keep converging.
  localparam logic [ITER_W-1:0] HYP_REPEAT_A = 5'd4;
  localparam logic [ITER_W-1:0] HYP_REPEAT_B = 5'd13;
  localparam logic [ITER_W-1:0] IDX_MAX      = 5'd31;

  // Hyperbolic shift index for a given step: starts at 1, and each repeat
  // index that has been passed pulls the sequence back by one.
  function automatic logic [ITER_W-1:0] hyp_index(input logic [ITER_W-1:0] step);
    logic [ITER_W:0] idx;
    idx = {1'b0, step} + 6'd1;
    if (step >= HYP_REPEAT_A) idx = idx - 6'd1;
    if (step > HYP_REPEAT_B)  idx = idx - 6'd1;
    return (idx > {1'b0, IDX_MAX}) ? IDX_MAX : idx[ITER_W-1:0];
  endfunction

endpackage

// File: rtl/cordic_iter_map.sv
// Maps the controller step counter to the shift/angle-table index
// presented to the single-step CORDIC core.
module cordic_iter_map
  import cordic_pkg::*;
(
  input  logic [ITER_W-1:0] i_step,
  input  logic              i_system,
  output logic [ITER_W-1:0] o_idx
);

  // NOTE: a single continuous assignment covers every input combination,
  // so there is no procedural path that could leave o_idx unassigned.
  assign o_idx = (i_system == SYS_CIRCULAR) ? i_step : hyp_index(i_step);

endmodule

// File: rtl/cordic_controller.sv
// Sequences one CORDIC operation through an external combinational step core.
// Define CORDIC_OVF_ABORT_EN to end an operation early on core overflow.
module cordic_controller
  import cordic_pkg::*;
#(
  parameter int p_WIDTH = 32,
  parameter int p_ITER  = 25
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  input  logic [p_WIDTH-1:0] i_x,
  input  logic [p_WIDTH-1:0] i_y,
  input  logic [p_WIDTH-1:0] i_z,
  input  logic               i_system,
  input  logic               i_mode,
  output logic               o_ready,
  output logic [p_WIDTH-1:0] o_core_x,
  output logic [p_WIDTH-1:0] o_core_y,
  output logic [p_WIDTH-1:0] o_core_z,
  output logic [4:0]         o_core_iter,
  output logic               o_core_system,
  output logic               o_core_mode,
  input  logic [p_WIDTH-1:0] i_core_x,
  input  logic [p_WIDTH-1:0] i_core_y,
  input  logic [p_WIDTH-1:0] i_core_z,
  input  logic               i_core_ovf,
  output logic               o_valid,
  output logic [p_WIDTH-1:0] o_x,
  output logic [p_WIDTH-1:0] o_y,
  output logic [p_WIDTH-1:0] o_z,
  output logic               o_ovf,
  input  logic               i_ready
);

`ifdef CORDIC_OVF_ABORT_EN
  localparam bit OVF_ABORT = 1'b1;
`else
  localparam bit OVF_ABORT = 1'b0;
`endif

  localparam logic [ITER_W-1:0] LAST_STEP = ITER_W'(p_ITER - 1);

  state_t              state_q;
  logic [ITER_W-1:0]   step_q;
  logic [p_WIDTH-1:0]  x_q, y_q, z_q;
  logic                sys_q, mode_q;
  logic                ovf_q, ready_q, valid_q;
  logic [ITER_W-1:0]   map_idx;

  cordic_iter_map u_iter_map (
    .i_step   (step_q),
    .i_system (sys_q),
    .o_idx    (map_idx)
  );

  // NOTE: every register here is written with non-blocking assignments so
  // all of them sample pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: the working registers are ordinary flops, not a memory array,
      // so they are reset and o_core_* shows a defined zero after reset.
      state_q <= ST_IDLE;
      step_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      sys_q   <= 1'b0;
      mode_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_valid && ready_q) begin
            x_q     <= i_x;
            y_q     <= i_y;
            z_q     <= i_z;
            sys_q   <= i_system;
            mode_q  <= i_mode;
            step_q  <= '0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b0;
            state_q <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (OVF_ABORT && i_core_ovf) begin
            // Discard the overflowed step; keep the last good values.
            ovf_q   <= 1'b1;
            valid_q <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            x_q    <= i_core_x;
            y_q    <= i_core_y;
            z_q    <= i_core_z;
            step_q <= step_q + 1'b1;
            if (i_core_ovf) ovf_q <= 1'b1;
            if (step_q == LAST_STEP) begin
              valid_q <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end

        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_ready       = ready_q;
  assign o_valid       = valid_q;
  assign o_core_x      = x_q;
  assign o_core_y      = y_q;
  assign o_core_z      = z_q;
  assign o_core_system = sys_q;
  assign o_core_mode   = mode_q;
  assign o_core_iter   = (state_q == ST_RUN) ? map_idx : '0;
  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_z           = z_q;
  assign o_ovf         = ovf_q;

endmodule

// File: tb/tb_cordic_controller.sv
// Self-checking bench for cordic_controller with a behavioural CORDIC step
// core and a queue of expected results. Honours CORDIC_OVF_ABORT_EN.
module tb_cordic_controller;
  import cordic_pkg::*;

  localparam int  W    = 32;
  localparam int  ITER = 25;
  localparam real PI   = 3.14159265358979323846;

  typedef struct packed {
    logic signed [31:0] x;
    logic signed [31:0] y;
    logic signed [31:0] z;
  } vec_t;

  typedef struct {
    vec_t v;
    logic ovf;
    int   lat;
    int   tol;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_valid, i_system, i_mode, i_ready;
  logic [W-1:0] i_x, i_y, i_z;
  logic         o_ready, o_valid, o_ovf, o_core_system, o_core_mode;
  logic [W-1:0] o_core_x, o_core_y, o_core_z, o_x, o_y, o_z;
  logic [4:0]   o_core_iter;
  logic [W-1:0] i_core_x, i_core_y, i_core_z;
  logic         i_core_ovf;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   hyp_seq[32];
  int   ovf_at  = -1;

  always #5 clk = ~clk;

  cordic_controller #(.p_WIDTH(W), .p_ITER(ITER)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_valid(i_valid), .i_x(i_x), .i_y(i_y), .i_z(i_z),
    .i_system(i_system), .i_mode(i_mode), .o_ready(o_ready),
    .o_core_x(o_core_x), .o_core_y(o_core_y), .o_core_z(o_core_z),
    .o_core_iter(o_core_iter), .o_core_system(o_core_system), .o_core_mode(o_core_mode),
    .i_core_x(i_core_x), .i_core_y(i_core_y), .i_core_z(i_core_z), .i_core_ovf(i_core_ovf),
    .o_valid(o_valid), .o_x(o_x), .o_y(o_y), .o_z(o_z), .o_ovf(o_ovf),
    .i_ready(i_ready)
  );

  // One CORDIC micro-rotation, the job of the external combinational core.
  function automatic vec_t core_step(vec_t v, logic [4:0] idx, logic sys, logic mode);
    vec_t n;
    logic signed [31:0] xs, ys, ang;
    real r, a;
    bit pos;
    xs = $signed(v.x) >>> idx;
    ys = $signed(v.y) >>> idx;
    r  = 2.0 ** (-1.0 * real'(idx));
    if (sys) a = $atan(r);
    else     a = (idx == 5'd0) ? 0.0 : $atanh(r);
    ang = int'(a / PI * 2147483648.0);
    pos = mode ? ($signed(v.z) >= 0) : ($signed(v.y) < 0);
    if (pos) begin
      n.x = sys ? v.x - ys : v.x + ys;
      n.y = v.y + xs;
      n.z = v.z - ang;
    end else begin
      n.x = sys ? v.x + ys : v.x - ys;
      n.y = v.y - xs;
      n.z = v.z + ang;
    end
    return n;
  endfunction

  function automatic vec_t ref_run(vec_t v, logic sys, logic mode, int n);
    vec_t c;
    c = v;
    for (int k = 0; k < n; k++)
      c = core_step(c, sys ? 5'(k) : 5'(hyp_seq[k]), sys, mode);
    return c;
  endfunction

  function automatic longint absd(logic signed [31:0] a, logic signed [31:0] b);
    longint d;
    d = longint'(a) - longint'(b);
    return (d < 0) ? -d : d;
  endfunction

  vec_t core_in, core_out;
  always_comb begin
    core_in  = '{x: o_core_x, y: o_core_y, z: o_core_z};
    core_out = core_step(core_in, o_core_iter, o_core_system, o_core_mode);
  end
  assign i_core_x   = core_out.x;
  assign i_core_y   = core_out.y;
  assign i_core_z   = core_out.z;
  assign i_core_ovf = (ovf_at >= 0) && (o_core_system == SYS_CIRCULAR) &&
                      (int'(o_core_iter) == ovf_at);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input vec_t v, input logic sys, input logic mode, input exp_t e);
    int n;
    n = 0;
    while (o_ready !== 1'b1 && n < 100) begin tick(); n++; end
    n_tests++;
    if (o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL start_ready: o_ready=%b after %0d cycles, required 1", o_ready, n);
    end
    i_x = v.x; i_y = v.y; i_z = v.z; i_system = sys; i_mode = mode; i_valid = 1'b1;
    sb.push_back(e);
    tick();
    i_valid = 1'b0;
  endtask

  // Waits (bounded) for o_valid; lat counts edges from the accepting edge.
  task automatic collect(output bit got, output int lat, output vec_t r, output logic ovf);
    lat = 1;
    while (o_valid !== 1'b1 && lat < 100) begin tick(); lat++; end
    got = (o_valid === 1'b1);
    r   = '{x: o_x, y: o_y, z: o_z};
    ovf = o_ovf;
  endtask

  task automatic test_reset();
    n_tests++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hs: ready=%b valid=%b, required 1 0", o_ready, o_valid);
    end
    n_tests++;
    if (o_core_iter !== 5'd0 || o_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_iter_ovf: iter=%0d ovf=%b, required 0 0", o_core_iter, o_ovf);
    end
    n_tests++;
    if ((o_x | o_y | o_z | o_core_x) !== '0) begin
      n_fail++;
      $display("FAIL reset_regs: x=%h y=%h z=%h, required 0", o_x, o_y, o_z);
    end
  endtask

  task automatic test_circular_rotation();
    vec_t v, r; exp_t e; bit got; int lat; logic ovf;
    v = '{x: 32'h4DBA76D4, y: 32'h0, z: 32'h20000000};
    e = '{v: '{x: 32'h5A82799A, y: 32'h5A82799A, z: 32'h0}, ovf: 1'b0, lat: ITER + 1, tol: 2048};
    start_op(v, SYS_CIRCULAR, MODE_ROTATION, e);
    collect(got, lat, r, ovf);
    e = sb.pop_front();
    n_tests++;
    if (!got || lat != e.lat) begin
      n_fail++;
      $display("FAIL rot45_latency: valid=%b lat=%0d, required 1 %0d", got, lat, e.lat);
    end
    n_tests++;
    if (absd(r.x, e.v.x) > e.tol || absd(r.y, e.v.y) > e.tol || absd(r.z, e.v.z) > e.tol) begin
      n_fail++;
      $display("FAIL rot45_xyz: got %h %h %h, required %h %h %h +/-%0d",
               r.x, r.y, r.z, e.v.x, e.v.y, e.v.z, e.tol);
    end
    n_tests++;
    if (ovf !== e.ovf) begin
      n_fail++;
      $display("FAIL rot45_ovf: got %b, required %b", ovf, e.ovf);
    end
    tick();
    n_tests++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rot45_retire: ready=%b valid=%b, required 1 0", o_ready, o_valid);
    end
  endtask

  task automatic test_hyperbolic_trace();
    vec_t v, r; exp_t e; int bad;
    v = '{x: 32'h40000000, y: 32'h0, z: 32'h08000000};
    e = '{v: ref_run(v, SYS_HYPERBOLIC, MODE_ROTATION, ITER), ovf: 1'b0, lat: ITER + 1, tol: 0};
    start_op(v, SYS_HYPERBOLIC, MODE_ROTATION, e);
    bad = 0;
    for (int s = 0; s < ITER; s++) begin
      n_tests++;
      if (o_core_iter !== 5'(hyp_seq[s])) begin
        n_fail++;
        $display("FAIL hyp_iter[%0d]: got %0d, required %0d", s, o_core_iter, hyp_seq[s]);
      end
      tick();
    end
    e = sb.pop_front();
    r = '{x: o_x, y: o_y, z: o_z};
    n_tests++;
    if (o_valid !== 1'b1 || r !== e.v || o_ovf !== e.ovf) begin
      n_fail++;
      $display("FAIL hyp_result: valid=%b xyz=%h %h %h ovf=%b, required 1 %h %h %h %b",
               o_valid, r.x, r.y, r.z, o_ovf, e.v.x, e.v.y, e.v.z, e.ovf);
    end
    tick();
  endtask

  task automatic test_done_hold();
    vec_t v, r; exp_t e; bit got; int lat; logic ovf;
    i_ready = 1'b0;
    v = '{x: 32'h30000000, y: 32'h20000000, z: 32'h0};
    e = '{v: ref_run(v, SYS_CIRCULAR, MODE_VECTORING, ITER), ovf: 1'b0, lat: ITER + 1, tol: 0};
    start_op(v, SYS_CIRCULAR, MODE_VECTORING, e);
    collect(got, lat, r, ovf);
    e = sb.pop_front();
    n_tests++;
    if (!got || lat != e.lat || r !== e.v || ovf !== e.ovf) begin
      n_fail++;
      $display("FAIL hold_result: valid=%b lat=%0d xyz=%h %h %h, required 1 %0d %h %h %h",
               got, lat, r.x, r.y, r.z, e.lat, e.v.x, e.v.y, e.v.z);
    end
    for (int c = 0; c < 10; c++) begin
      i_valid = c[0];
      i_x = $urandom; i_y = $urandom; i_z = $urandom;
      tick();
      r = '{x: o_x, y: o_y, z: o_z};
      n_tests++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || r !== e.v || o_ovf !== e.ovf) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: valid=%b ready=%b xyz=%h %h %h, required 1 0 %h %h %h",
                 c, o_valid, o_ready, r.x, r.y, r.z, e.v.x, e.v.y, e.v.z);
      end
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    tick();
    n_tests++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release: ready=%b valid=%b, required 1 0", o_ready, o_valid);
    end
    tick();
    n_tests++;
    if (o_ready !== 1'b1 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL hold_no_queue: ready=%b pending=%0d, required 1 0", o_ready, sb.size());
    end
  endtask

  task automatic test_overflow();
    vec_t v, r; exp_t e; bit got; int lat; logic ovf;
    v = '{x: 32'h4DBA76D4, y: 32'h0, z: 32'h20000000};
`ifdef CORDIC_OVF_ABORT_EN
    e = '{v: ref_run(v, SYS_CIRCULAR, MODE_ROTATION, 7), ovf: 1'b1, lat: 9, tol: 0};
`else
    e = '{v: ref_run(v, SYS_CIRCULAR, MODE_ROTATION, ITER), ovf: 1'b1, lat: ITER + 1, tol: 0};
`endif
    ovf_at = 7;
    start_op(v, SYS_CIRCULAR, MODE_ROTATION, e);
    collect(got, lat, r, ovf);
    e = sb.pop_front();
    n_tests++;
    if (!got || lat != e.lat) begin
      n_fail++;
      $display("FAIL ovf_latency: valid=%b lat=%0d, required 1 %0d", got, lat, e.lat);
    end
    n_tests++;
    if (r !== e.v || ovf !== e.ovf) begin
      n_fail++;
      $display("FAIL ovf_result: xyz=%h %h %h ovf=%b, required %h %h %h %b",
               r.x, r.y, r.z, ovf, e.v.x, e.v.y, e.v.z, e.ovf);
    end
    tick();
    ovf_at = -1;
  endtask

  task automatic test_reset_mid_run();
    vec_t v, r; exp_t e; bit got; int lat; logic ovf;
    v = '{x: 32'h4DBA76D4, y: 32'h0, z: 32'h10000000};
    e = '{v: ref_run(v, SYS_CIRCULAR, MODE_ROTATION, ITER), ovf: 1'b0, lat: ITER + 1, tol: 0};
    start_op(v, SYS_CIRCULAR, MODE_ROTATION, e);
    repeat (12) tick();
    n_tests++;
    if (o_core_iter !== 5'd12) begin
      n_fail++;
      $display("FAIL rst_step12: iter=%0d, required 12", o_core_iter);
    end
    #2 rst_n = 1'b0;
    #1;
    void'(sb.pop_front());
    n_tests++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_core_iter !== 5'd0) begin
      n_fail++;
      $display("FAIL rst_async: valid=%b ready=%b iter=%0d, required 0 1 0", o_valid, o_ready, o_core_iter);
    end
    tick();
    #2 rst_n = 1'b1;
    tick();
    n_tests++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || (o_x | o_y | o_z) !== '0 || o_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_release: valid=%b ready=%b x=%h ovf=%b, required 0 1 0 0", o_valid, o_ready, o_x, o_ovf);
    end
    v = '{x: 32'h40000000, y: 32'h20000000, z: 32'h0};
    e = '{v: ref_run(v, SYS_HYPERBOLIC, MODE_VECTORING, ITER), ovf: 1'b0, lat: ITER + 1, tol: 0};
    start_op(v, SYS_HYPERBOLIC, MODE_VECTORING, e);
    collect(got, lat, r, ovf);
    e = sb.pop_front();
    n_tests++;
    if (!got || lat != e.lat || r !== e.v || ovf !== e.ovf) begin
      n_fail++;
      $display("FAIL rst_next_op: valid=%b lat=%0d xyz=%h %h %h ovf=%b, required 1 %0d %h %h %h %b",
               got, lat, r.x, r.y, r.z, ovf, e.lat, e.v.x, e.v.y, e.v.z, e.ovf);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    vec_t ops[3]; logic sys[3]; logic mode[3];
    int acc_cyc[3]; int cyc, next, done; bit accepting;
    vec_t r; exp_t e;
    ops[0] = '{x: 32'h30000000, y: 32'h20000000, z: 32'h0};  sys[0] = SYS_CIRCULAR;   mode[0] = MODE_VECTORING;
    ops[1] = '{x: 32'h40000000, y: 32'h0, z: 32'hF8000000};  sys[1] = SYS_HYPERBOLIC; mode[1] = MODE_ROTATION;
    ops[2] = '{x: 32'h4DBA76D4, y: 32'h0, z: 32'hE0000000};  sys[2] = SYS_CIRCULAR;   mode[2] = MODE_ROTATION;
    i_ready = 1'b1;
    next = 0; done = 0; cyc = 0;
    i_x = ops[0].x; i_y = ops[0].y; i_z = ops[0].z; i_system = sys[0]; i_mode = mode[0];
    i_valid = 1'b1;
    while (done < 3 && cyc < 200) begin
      accepting = 1'b0;
      if (o_valid === 1'b1) begin
        r = '{x: o_x, y: o_y, z: o_z};
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_extra: result %h %h %h at cycle %0d, required none", r.x, r.y, r.z, cyc);
        end else begin
          e = sb.pop_front();
          if (r !== e.v || o_ovf !== e.ovf || cyc != e.lat) begin
            n_fail++;
            $display("FAIL b2b_result%0d: xyz=%h %h %h cyc=%0d, required %h %h %h cyc=%0d",
                     done, r.x, r.y, r.z, cyc, e.v.x, e.v.y, e.v.z, e.lat);
          end
        end
        done++;
      end
      if (o_ready === 1'b1 && i_valid && next < 3) begin
        e = '{v: ref_run(ops[next], sys[next], mode[next], ITER), ovf: 1'b0, lat: cyc + ITER + 1, tol: 0};
        sb.push_back(e);
        acc_cyc[next] = cyc;
        accepting = 1'b1;
      end
      tick();
      cyc++;
      if (accepting) begin
        next++;
        if (next < 3) begin
          i_x = ops[next].x; i_y = ops[next].y; i_z = ops[next].z;
          i_system = sys[next]; i_mode = mode[next];
        end else begin
          i_valid = 1'b0;
        end
      end
    end
    i_valid = 1'b0;
    n_tests++;
    if (done != 3 || next != 3 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_count: results=%0d accepts=%0d pending=%0d, required 3 3 0", done, next, sb.size());
    end
    n_tests++;
    if (next == 3 && (acc_cyc[1] - acc_cyc[0] != ITER + 2 || acc_cyc[2] - acc_cyc[1] != ITER + 2)) begin
      n_fail++;
      $display("FAIL b2b_spacing: %0d %0d, required %0d", acc_cyc[1] - acc_cyc[0],
               acc_cyc[2] - acc_cyc[1], ITER + 2);
    end
    sb.delete();
  endtask

  initial begin
    int k; bit rep_a, rep_b;
    k = 1; rep_a = 1'b0; rep_b = 1'b0;
    for (int s = 0; s < 32; s++) begin
      hyp_seq[s] = k;
      if (k == 4 && !rep_a)       rep_a = 1'b1;
      else if (k == 13 && !rep_b) rep_b = 1'b1;
      else if (k < 31)            k++;
    end
    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_x = '0; i_y = '0; i_z = '0; i_system = SYS_CIRCULAR; i_mode = MODE_ROTATION;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    test_reset();
    test_circular_rotation();
    test_hyperbolic_trace();
    test_done_hold();
    test_overflow();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/cordic_controller.md
CORDIC_CONTROLLER -- requirements
Module: cordic_controller

Interface
REQ-001 SHALL have parameter p_WIDTH, default 32, datapath width of x, y and z.
REQ-002 SHALL have parameter p_ITER, default 25, CORDIC steps per operation (2..31).
REQ-003 SHALL have input i_clk, 1 bit, the single clock.
REQ-004 SHALL have input i_rst_n, 1 bit; reset is asynchronous and active-low.
REQ-005 SHALL have inputs i_valid (1 bit, operation request) and i_x, i_y (p_WIDTH bits each, signed fixed-point).
REQ-006 SHALL have input i_z, p_WIDTH bits, signed binary angle (2^(p_WIDTH-1) = 180 deg).
REQ-007 SHALL have inputs i_system (1 bit: 1 circular, 0 hyperbolic) and i_mode (1 bit: 1 rotation, 0 vectoring).
REQ-008 SHALL have output o_ready, 1 bit, high when a request can be accepted.
REQ-009 SHALL have outputs o_core_x, o_core_y, o_core_z (p_WIDTH each), o_core_iter (5 bits), o_core_system and o_core_mode (1 bit each), all driven to the combinational core.
REQ-010 SHALL have inputs i_core_x, i_core_y, i_core_z (p_WIDTH each) and i_core_ovf (1 bit), the core's single-step result.
REQ-011 SHALL have outputs o_valid (1 bit), o_x, o_y, o_z (p_WIDTH each) and o_ovf (1 bit), and input i_ready (1 bit, result accepted).

Function
REQ-012 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-013 IDLE: o_ready=1; i_valid&&o_ready latches x, y, z, system, mode into working registers, clears step counter and overflow flag, enters RUN.
REQ-014 RUN: o_core_* SHALL present the working registers and the mapped iteration index; each cycle the working registers load i_core_x/y/z and the step counter increments.
REQ-015 Leaving RUN SHALL occur on the clock edge that consumes step p_ITER-1, entering DONE; latency from accept to o_valid = p_ITER+1 cycles.
REQ-016 Index map: circular idx = step; hyperbolic idx sequence 1,2,3,4,4,5,...,13,13,14,... (4 and 13 repeated), saturating at 31.
REQ-017 i_core_ovf sampled high in RUN SHALL set a sticky overflow flag.
REQ-018 DONE: o_valid=1, o_x/o_y/o_z/o_ovf hold the final values stable until i_valid&&... i.e. until i_ready=1, then return to IDLE.
REQ-019 o_ready SHALL be 0 in RUN and DONE; requests then are ignored, not queued.
REQ-020 o_valid&&i_ready and a new i_valid in the same cycle: the result is retired; the new request is accepted only on the next cycle (o_ready=1 only in IDLE).
REQ-021 o_core_iter SHALL be 0 and o_core_x/y/z SHALL mirror the working registers outside RUN; the core output is ignored outside RUN.

Reset
REQ-022 i_rst_n low SHALL asynchronously force IDLE, step counter 0, working registers 0, overflow flag 0, o_valid 0, o_ready 1 after release; reset mid-RUN or mid-DONE abandons the operation with no output.

Configuration
REQ-023 Macro CORDIC_OVF_ABORT_EN defined: i_core_ovf in RUN SHALL end RUN immediately into DONE with o_ovf=1 and registers holding the last non-overflowed values (core result of that step discarded).
REQ-024 Without CORDIC_OVF_ABORT_EN: overflow SHALL only set the sticky o_ovf; all p_ITER steps run and latency is fixed.

Structure
REQ-025 Shared package cordic_pkg SHALL hold the FSM state enum, system/mode encodings and the hyperbolic repeat indices (4, 13).
REQ-026 Sub-module cordic_iter_map (step, system -> idx) SHALL implement REQ-016 combinationally.

Verification
REQ-027 Circular rotation, x=0x4DBA76D4 (0.60725), y=0, z=0x20000000 (45 deg) -> o_x≈o_y≈0.70711 within 2^-20, o_z≈0, o_ovf=0, o_valid 26 cycles after accept.
REQ-028 Hyperbolic run: o_core_iter trace over 25 steps = 1,2,3,4,4,5..13,13,14..23.
REQ-029 Hold i_ready=0 for 10 cycles in DONE -> outputs stable, o_ready=0, extra i_valid pulses ignored; i_ready=1 -> IDLE next cycle.
REQ-030 Force i_core_ovf=1 at step 7 -> with macro o_valid at step 8 cycle, o_ovf=1; without, o_valid at cycle 26, o_ovf=1.
REQ-031 Drop i_rst_n at step 12 -> o_valid=0, o_ready=1 after release; next request completes normally.
REQ-032 Back-to-back: i_valid held high with i_ready=1 -> one accept per 27 cycles, no lost or duplicated results.
